// File: rtl/piso_out_pkg.sv
// Shared definitions for the PISO output controller: FSM state type and
// the SHIFT_OUT levels the external shifter interprets as load / shift.
package piso_out_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } piso_state_e;

    // SHIFT_OUT levels: 0 makes the shifter capture its parallel inputs,
    // 1 makes it shift (when enabled) or hold.
    localparam logic SHIFT_LOAD = 1'b0;
    localparam logic SHIFT_HOLD = 1'b1;

endpackage

// File: rtl/piso_out_argmax.sv
// Running argmax tracker for the PISO output stream. Only present when
// PISO_OUT_ARGMAX_EN is defined. Beats arrive in descending tap order, so a
// ">=" replacement leaves ties on the lowest tap index.
`ifdef PISO_OUT_ARGMAX_EN
module piso_out_argmax #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 2
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             init_i,
    input  logic             beat_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [IDX_W-1:0] argmax_o,
    output logic [WIDTH-1:0] argmax_val_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] val_q, val_d;

    // Next running maximum: cleared at frame load, replaced on >= beats.
    always_comb begin
        idx_d = idx_q;
        val_d = val_q;
        if (init_i) begin
            idx_d = '0;
            val_d = '0;
        end else if (beat_i && (data_i >= val_q)) begin
            idx_d = idx_i;
            val_d = data_i;
        end
    end

    // Maximum registers, cleared by the controller reset.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            idx_q <= '0;
            val_q <= '0;
        end else begin
            idx_q <= idx_d;
            val_q <= val_d;
        end
    end

    assign argmax_o     = idx_q;
    assign argmax_val_o = val_q;

endmodule
`endif

// File: rtl/piso_out_ctrl.sv
// PISO output controller: loads the external shifter once per frame, then
// streams NUM_TAPS beats (tap NUM_TAPS-1 first) over a valid/ready port and
// pulses DONE. Optional argmax tracking is enabled by PISO_OUT_ARGMAX_EN.
module piso_out_ctrl
    import piso_out_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_TAPS = 4,
    parameter int IDX_W    = $clog2(NUM_TAPS)
) (
    input  logic             CLKEXT,
    input  logic             CLR_PISO_OUT,
    input  logic             START,
    input  logic [WIDTH-1:0] TAP_DATA,
    output logic             SHIFT_OUT,
    output logic             EN_PISO_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [IDX_W-1:0] OUT_IDX,
    output logic             BUSY,
    output logic             DONE
`ifdef PISO_OUT_ARGMAX_EN
    ,
    output logic [IDX_W-1:0] ARGMAX,
    output logic [WIDTH-1:0] ARGMAX_VAL
`endif
);

    piso_state_e      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    // State and beat counter registers; reset aborts any frame in flight.
    always_ff @(posedge CLKEXT or posedge CLR_PISO_OUT) begin
        if (CLR_PISO_OUT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and all control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        SHIFT_OUT   = SHIFT_HOLD;
        EN_PISO_OUT = 1'b0;
        OUT_VALID   = 1'b0;
        BUSY        = 1'b1;
        DONE        = 1'b0;
        unique case (state_q)
            IDLE: begin
                BUSY = 1'b0;
                if (START) state_d = LOAD;
            end
            LOAD: begin
                SHIFT_OUT = SHIFT_LOAD;
                cnt_d     = IDX_W'(NUM_TAPS - 1);
                state_d   = SEND;
            end
            SEND: begin
                OUT_VALID = 1'b1;
                // The final beat (index 0) is presented without shifting.
                EN_PISO_OUT = OUT_READY && (cnt_q != '0);
                if (OUT_READY) begin
                    if (cnt_q == '0) state_d = FIN;
                    else             cnt_d   = cnt_q - IDX_W'(1);
                end
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign OUT_DATA = TAP_DATA;
    assign OUT_IDX  = cnt_q;

`ifdef PISO_OUT_ARGMAX_EN
    piso_out_argmax #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_argmax (
        .clk_i        (CLKEXT),
        .clr_i        (CLR_PISO_OUT),
        .init_i       (state_q == LOAD),
        .beat_i       (OUT_VALID && OUT_READY),
        .data_i       (TAP_DATA),
        .idx_i        (cnt_q),
        .argmax_o     (ARGMAX),
        .argmax_val_o (ARGMAX_VAL)
    );
`endif

endmodule

// File: tb/tb_piso_out_ctrl.sv
// Self-checking bench for piso_out_ctrl (WIDTH=8, NUM_TAPS=4). The bench
// models the external parallel-in/serial-out shifter so OUT_DATA carries
// real tap values. Argmax checks are compiled in with PISO_OUT_ARGMAX_EN.
module tb_piso_out_ctrl;

    localparam int WIDTH    = 8;
    localparam int NUM_TAPS = 4;
    localparam int IDX_W    = 2;

    logic             CLKEXT = 1'b0;
    logic             CLR_PISO_OUT;
    logic             START;
    logic [WIDTH-1:0] TAP_DATA;
    logic             SHIFT_OUT;
    logic             EN_PISO_OUT;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic [IDX_W-1:0] OUT_IDX;
    logic             BUSY;
    logic             DONE;
`ifdef PISO_OUT_ARGMAX_EN
    logic [IDX_W-1:0] ARGMAX;
    logic [WIDTH-1:0] ARGMAX_VAL;
`endif

    piso_out_ctrl #(
        .WIDTH    (WIDTH),
        .NUM_TAPS (NUM_TAPS),
        .IDX_W    (IDX_W)
    ) dut (
        .CLKEXT       (CLKEXT),
        .CLR_PISO_OUT (CLR_PISO_OUT),
        .START        (START),
        .TAP_DATA     (TAP_DATA),
        .SHIFT_OUT    (SHIFT_OUT),
        .EN_PISO_OUT  (EN_PISO_OUT),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_DATA     (OUT_DATA),
        .OUT_IDX      (OUT_IDX),
        .BUSY         (BUSY),
        .DONE         (DONE)
`ifdef PISO_OUT_ARGMAX_EN
        ,
        .ARGMAX       (ARGMAX),
        .ARGMAX_VAL   (ARGMAX_VAL)
`endif
    );

    always #5 CLKEXT = ~CLKEXT;

    // External shifter model: next_frame[i] is the value for tap i.
    logic [WIDTH-1:0] next_frame [NUM_TAPS];
    logic [WIDTH-1:0] sh [NUM_TAPS] = '{default: '0};
    int               ptr = 0;
    bit               ld_s, en_s;

    always begin
        @(negedge CLKEXT);
        #3;
        ld_s = (SHIFT_OUT == 1'b0);
        en_s = EN_PISO_OUT;
        @(posedge CLKEXT);
        if (ld_s) begin
            for (int i = 0; i < NUM_TAPS; i++) sh[i] <= next_frame[i];
            ptr <= NUM_TAPS - 1;
        end else if (en_s && ptr > 0) begin
            ptr <= ptr - 1;
        end
    end

    assign TAP_DATA = sh[ptr];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [6:0] outs();
        return {SHIFT_OUT, OUT_VALID, EN_PISO_OUT, BUSY, DONE, OUT_IDX};
    endfunction

    // Per-cycle vector: inputs applied in a cycle, outputs expected in it.
    typedef struct {
        logic             start;
        logic             ready;
        logic             shift;
        logic             valid;
        logic             en;
        logic             busy;
        logic             done;
        logic [IDX_W-1:0] idx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic r, logic sh_o, logic v, logic e,
                                logic b, logic d, logic [IDX_W-1:0] ix);
        vec_t t;
        t.start = s; t.ready = r; t.shift = sh_o; t.valid = v;
        t.en = e; t.busy = b; t.done = d; t.idx = ix;
        return t;
    endfunction

    task automatic apply_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            START     = tbl[i].start;
            OUT_READY = tbl[i].ready;
            #1;
            chk($sformatf("%s_c%0d", name, i), 64'(outs()),
                64'({tbl[i].shift, tbl[i].valid, tbl[i].en, tbl[i].busy,
                     tbl[i].done, tbl[i].idx}));
            if (tbl[i].valid)
                chk($sformatf("%s_data_c%0d", name, i), 64'(OUT_DATA),
                    64'(next_frame[tbl[i].idx]));
            @(negedge CLKEXT);
        end
        START = 1'b0;
    endtask

    // One frame against the transaction-level expectation: beats carry taps
    // NUM_TAPS-1..0 in order, one DONE, one load, latency NUM_TAPS+2 plus
    // stalled cycles, stalled beats unchanged. Entered and left on a negedge.
    task automatic run_frame(input int ready_pct, input bit stray, input int tail,
                             input string tag);
        int cyc = 0, done_cnt = 0, done_cyc = -1, shl = 0, stall = 0;
        int holdbad = 0, nbeats = 0, beatbad = 0, e_idx;
        bit pv = 1'b0;
        logic [IDX_W-1:0] pidx = '0;
        logic [WIDTH-1:0] pdat = '0;
`ifdef PISO_OUT_ARGMAX_EN
        logic [IDX_W-1:0] am = '0;
        logic [WIDTH-1:0] amv = '0;
        int best = 0;
        for (int i = 1; i < NUM_TAPS; i++)
            if (next_frame[i] > next_frame[best]) best = i;
`endif
        while (cyc < 300) begin
            START     = (cyc == 0) ? 1'b1
                      : (stray && done_cnt == 0 && $urandom_range(0, 2) == 0);
            OUT_READY = ($urandom_range(1, 100) <= ready_pct);
            #1;
            if (pv && (OUT_IDX !== pidx || OUT_DATA !== pdat || OUT_VALID !== 1'b1))
                holdbad++;
            pv   = OUT_VALID && !OUT_READY;
            pidx = OUT_IDX;
            pdat = OUT_DATA;
            if (SHIFT_OUT === 1'b0) shl++;
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b0) stall++;
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                e_idx = NUM_TAPS - 1 - nbeats;
                if (nbeats >= NUM_TAPS || OUT_IDX !== IDX_W'(e_idx)
                    || OUT_DATA !== next_frame[e_idx]) beatbad++;
                nbeats++;
            end
            if (DONE === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
`ifdef PISO_OUT_ARGMAX_EN
                    am  = ARGMAX;
                    amv = ARGMAX_VAL;
`endif
                end
            end
            @(negedge CLKEXT);
            cyc++;
            if (done_cyc >= 0 && cyc > done_cyc + tail) break;
        end
        START = 1'b0;
        chk({tag, "_nbeats"}, 64'(nbeats), 64'(NUM_TAPS));
        chk({tag, "_beat_content"}, 64'(beatbad), 64'd0);
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_load_count"}, 64'(shl), 64'd1);
        chk({tag, "_latency"}, 64'(done_cyc), 64'(NUM_TAPS + 2 + stall));
        chk({tag, "_stall_hold"}, 64'(holdbad), 64'd0);
`ifdef PISO_OUT_ARGMAX_EN
        chk({tag, "_argmax"}, 64'(am), 64'(best));
        chk({tag, "_argmax_val"}, 64'(amv), 64'(next_frame[best]));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        CLR_PISO_OUT = 1'b1;
        START        = 1'b0;
        OUT_READY    = 1'b0;
        next_frame[0] = 8'hE7; next_frame[1] = 8'h19;
        next_frame[2] = 8'h5C; next_frame[3] = 8'hA3;
        @(negedge CLKEXT);
        @(negedge CLKEXT);
        #1;
        chk("reset_state", 64'(outs()), 64'(7'b1_0_0_0_0_00));
        @(negedge CLKEXT);
        CLR_PISO_OUT = 1'b0;
        @(negedge CLKEXT);

        // Basic frame, OUT_READY held high: DONE in cycle 6.
        tbl.delete();
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2'd0)); // IDLE, START taken
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2'd0)); // LOAD
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 2'd3));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 2'd2));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 2'd1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 2'd0)); // last beat, no shift
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 2'd0)); // FIN
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2'd0)); // IDLE
        apply_table("basic");

        // Second beat stalled for 3 cycles: DONE in cycle 9.
        tbl.delete();
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 2'd3));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 2'd2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 2'd2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 2'd2));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 2'd2));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 2'd1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 2'd0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 2'd0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2'd0));
        apply_table("stall");

        // Stray START pulses during LOAD/SEND/FIN must be ignored.
        run_frame(100, 1'b1, 3, "stray_start");

        // Reset after the first accepted beat.
        START = 1'b1; OUT_READY = 1'b1;
        @(negedge CLKEXT);            // LOAD
        START = 1'b0;
        @(negedge CLKEXT);            // beat idx 3 accepted
        @(negedge CLKEXT);            // beat idx 2 presented
        #1 CLR_PISO_OUT = 1'b1;
        #1;
        chk("clr_immediate", 64'(outs()), 64'(7'b1_0_0_0_0_00));
        @(negedge CLKEXT);
        CLR_PISO_OUT = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || OUT_VALID !== 1'b0) bad++;
            @(negedge CLKEXT);
        end
        chk("clr_no_done", 64'(bad), 64'd0);
        run_frame(100, 1'b0, 3, "post_clr");

        // Back-to-back: second START in the first IDLE cycle after DONE.
        next_frame[0] = 8'h3C; next_frame[1] = 8'hC3;
        next_frame[2] = 8'h00; next_frame[3] = 8'hFF;
        run_frame(100, 1'b0, 0, "b2b_first");
        run_frame(100, 1'b0, 3, "b2b_second");

`ifdef PISO_OUT_ARGMAX_EN
        next_frame[0] = 8'h05; next_frame[1] = 8'h7F;
        next_frame[2] = 8'h7F; next_frame[3] = 8'h10;
        run_frame(100, 1'b0, 3, "argmax_tie");
`endif

        // Randomized frames with random backpressure and stray STARTs.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NUM_TAPS; i++)
                next_frame[i] = ($urandom_range(0, 1) == 1)
                              ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
            run_frame(int'($urandom_range(30, 100)), 1'b1,
                      int'($urandom_range(0, 2)), $sformatf("rand%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/piso_out_ctrl.md
PISO_OUT_CTRL -- requirements
Module: piso_out_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, tap data width in bits.
REQ-002 SHALL have parameter NUM_TAPS, default 4, taps per frame; legal range 2..256.
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_TAPS), tap index width.
REQ-004 SHALL have port CLKEXT  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port CLR_PISO_OUT  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port START  input  1  frame-ready pulse from the compute array.
REQ-007 SHALL have port TAP_DATA  input  WIDTH  current shifter output, tap NUM_TAPS-1.
REQ-008 SHALL have port SHIFT_OUT  output  1  shifter mode: 0 = parallel load, 1 = shift/hold.
REQ-009 SHALL have port EN_PISO_OUT  output  1  shifter advance enable.
REQ-010 SHALL have port OUT_VALID  output  1  downstream beat valid.
REQ-011 SHALL have port OUT_READY  input  1  downstream beat accept.
REQ-012 SHALL have port OUT_DATA  output  WIDTH  beat payload, equal to TAP_DATA.
REQ-013 SHALL have port OUT_IDX  output  IDX_W  source tap index of the current beat.
REQ-014 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-015 SHALL have port DONE  output  1  one-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SEND, FIN.
- IDLE -> LOAD when START=1.
- LOAD -> SEND unconditionally.
- SEND -> FIN on the accepted beat with OUT_IDX=0.
- FIN -> IDLE unconditionally.
REQ-017 SHALL drive SHIFT_OUT=0 only in LOAD and SHIFT_OUT=1 in all other states, so the shifter captures exactly once per frame.
REQ-018 SHALL assert OUT_VALID only in SEND.
REQ-019 SHALL drive OUT_DATA=TAP_DATA combinationally.
REQ-020 SHALL drive EN_PISO_OUT = OUT_VALID & OUT_READY & (OUT_IDX != 0), combinationally, so the last beat does not shift.
REQ-021 SHALL load the beat counter with NUM_TAPS-1 in LOAD and decrement it on each accepted beat; OUT_IDX equals the counter, giving tap order NUM_TAPS-1 down to 0.
REQ-022 SHALL hold OUT_DATA, OUT_IDX and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 SHALL pulse DONE high for exactly one cycle, in FIN.
REQ-024 SHALL ignore START in LOAD, SEND and FIN, with no queuing.
REQ-025 SHALL treat START and FIN in the same cycle as ignored; a new START is accepted only in IDLE.
REQ-026 SHALL give a minimum frame latency of NUM_TAPS+2 cycles from START to DONE at OUT_READY=1.

Reset
REQ-027 SHALL, on CLR_PISO_OUT=1 at any time, including mid-frame, immediately force state IDLE, counter 0, SHIFT_OUT=1, EN_PISO_OUT=0, OUT_VALID=0, BUSY=0, DONE=0, OUT_IDX=0.
REQ-028 SHALL discard any partial frame on reset, with no DONE.
REQ-029 SHALL, with PISO_OUT_ARGMAX_EN defined, also clear the argmax registers on reset.

Configuration
REQ-030 SHALL, when macro PISO_OUT_ARGMAX_EN is defined, add output ARGMAX (IDX_W) and output ARGMAX_VAL (WIDTH).
REQ-031 SHALL, with PISO_OUT_ARGMAX_EN, on each accepted beat update the running maximum to the beat if TAP_DATA >= the current maximum (unsigned), so ties resolve to the lower tap index.
REQ-032 SHALL, with PISO_OUT_ARGMAX_EN, re-initialise the running maximum in LOAD.
REQ-033 SHALL, with PISO_OUT_ARGMAX_EN, hold ARGMAX and ARGMAX_VAL valid from FIN until the next LOAD.
REQ-034 SHALL, without PISO_OUT_ARGMAX_EN, have no ARGMAX or ARGMAX_VAL ports and no compare logic.

Structure
REQ-035 SHALL place the FSM state typedef (IDLE/LOAD/SEND/FIN) in shared package piso_out_pkg.
REQ-036 SHALL place the encoding constants for SHIFT_OUT load/shift levels in piso_out_pkg.
REQ-037 SHALL, with PISO_OUT_ARGMAX_EN defined, instantiate the argmax tracker as one sub-module, piso_out_argmax.

Verification
REQ-038 SHALL test: WIDTH=8, NUM_TAPS=4, START with OUT_READY=1 -> SHIFT_OUT low 1 cycle; 4 beats with OUT_IDX 3,2,1,0; 3 EN_PISO_OUT pulses; DONE at cycle 6.
REQ-039 SHALL test: OUT_READY low for 3 cycles on beat 2 -> OUT_DATA and OUT_IDX held, EN_PISO_OUT=0, frame completes with DONE at cycle 9.
REQ-040 SHALL test: START pulsed during SEND -> ignored; exactly one DONE; SHIFT_OUT low only once.
REQ-041 SHALL test: CLR_PISO_OUT asserted after beat 1 -> outputs at reset values immediately; no DONE; next START gives a full 4-beat frame.
REQ-042 SHALL test, with PISO_OUT_ARGMAX_EN, taps [3..0] = 0x10,0x7F,0x7F,0x05 -> ARGMAX=1, ARGMAX_VAL=0x7F at DONE.
REQ-043 SHALL test: back-to-back START on the cycle after DONE -> accepted; second frame identical to the first.
